bias_act_stage: RTL and testbench

Post-accumulation stage for one layer's convolution datapath. It takes the N_adder_tree lane sums from the adder trees and the matching per-lane constant bias vector, then produces one registered output beat per input beat. Each lane is bias-added, right-shifted, saturated and optionally ReLU-clamped. The stage sits between the adder trees and the activation buffer, is a two-stage elastic pipeline with valid/ready backpressure, and tags every output beat with its output-channel-group index.

---
 rtl/bias_act_pkg.sv | 20 ++
 rtl/bias_act_lane.sv | 65 ++++++
 rtl/bias_act_stage.sv | 88 ++++++++
 tb/tb_bias_act_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_act_pkg.sv
// Shared constants and helpers for the bias/activation post-accumulation stage.
// Used by bias_act_lane and bias_act_stage; see lane file for BIAS_ACT_RELU_EN.
package bias_act_pkg;

  localparam int BIAS_W = 18;

  // Low bit of lane 'lane' in a vector packed as equal-width lanes of 'w' bits.
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

  function automatic int sat_max(input int out_w);
    return (2 ** (out_w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int out_w);
    return -(2 ** (out_w - 1));
  endfunction

endpackage

// File: rtl/bias_act_lane.sv
// One lane of the stage: bias add (S1), then shift/saturate/optional ReLU (S2).
// Define BIAS_ACT_RELU_EN to clamp negative results to zero after saturation.
module bias_act_lane
  import bias_act_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int OUT_W = 18,
  parameter int SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s1_load,
  input  logic                    s2_load,
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [BIAS_W-1:0] bias,
  output logic signed [OUT_W-1:0] act,
  output logic                    sat
);

  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] MAXV = SW'(sat_max(OUT_W));
  localparam logic signed [SW-1:0] MINV = SW'(sat_min(OUT_W));

  logic signed [SW-1:0]    sum;
  logic signed [SW-1:0]    sh;
  logic signed [OUT_W-1:0] res;
  logic                    res_sat;

  // S1 holds only data; its valid bit lives in the top level, so no reset needed.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      sum <= SW'(acc) + SW'(bias);
    end
  end

  always_comb begin
    sh      = sum >>> SHIFT;
    res     = sh[OUT_W-1:0];
    res_sat = 1'b0;
    if (sh > MAXV) begin
      res     = MAXV[OUT_W-1:0];
      res_sat = 1'b1;
    end else if (sh < MINV) begin
      res     = MINV[OUT_W-1:0];
      res_sat = 1'b1;
    end
`ifdef BIAS_ACT_RELU_EN
    // The saturation flag still reports the pre-ReLU clamp.
    if (res[OUT_W-1]) begin
      res = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act <= '0;
      sat <= 1'b0;
    end else if (s2_load) begin
      act <= res;
      sat <= res_sat;
    end
  end

endmodule

// File: rtl/bias_act_stage.sv
// Two-stage elastic bias/shift/saturate stage with output-channel-group tagging.
// Optional ReLU is selected by BIAS_ACT_RELU_EN (handled inside bias_act_lane).
module bias_act_stage
  import bias_act_pkg::*;
#(
  parameter int N_adder_tree = 16,
  parameter int ACC_W        = 24,
  parameter int OUT_W        = 18,
  parameter int SHIFT        = 4,
  parameter int N_GROUPS     = 61,
  localparam int GW          = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_adder_tree*ACC_W-1:0]   in_acc,
  input  logic [N_adder_tree*BIAS_W-1:0]  bias,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_adder_tree*OUT_W-1:0]   out_act,
  output logic [N_adder_tree-1:0]         out_sat,
  output logic [GW-1:0]                   out_group,
  output logic                            out_last
);

  localparam logic [GW-1:0] LAST_GRP = GW'(N_GROUPS - 1);

  logic s1_valid;
  logic s2_valid;
  logic s2_load;
  logic s1_adv;
  logic in_xfer;
  logic out_xfer;
  logic [GW-1:0] grp;

  // S2 refills whenever it is empty or being drained; S1 moves only into a loading S2.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_load;
  assign in_ready  = !s1_valid || s2_load;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = s2_valid && out_ready;
  assign out_valid = s2_valid;
  assign out_group = grp;
  assign out_last  = (grp == LAST_GRP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp <= '0;
    end else if (out_xfer) begin
      grp <= (grp == LAST_GRP) ? '0 : grp + 1'b1;
    end
  end

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_act_lane #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .s1_load (in_xfer),
      .s2_load (s1_adv),
      .acc     (in_acc[lane_lo(i, ACC_W) +: ACC_W]),
      .bias    (bias[lane_lo(i, BIAS_W) +: BIAS_W]),
      .act     (out_act[lane_lo(i, OUT_W) +: OUT_W]),
      .sat     (out_sat[i])
    );
  end

endmodule

// File: tb/tb_bias_act_stage.sv
// Randomized self-checking bench for bias_act_stage against a queue-based reference model.
// Honors BIAS_ACT_RELU_EN the same way the design does.
module tb_bias_act_stage;
  import bias_act_pkg::*;

  localparam int N        = 16;
  localparam int ACC_W    = 24;
  localparam int OUT_W    = 18;
  localparam int SHIFT    = 4;
  localparam int N_GROUPS = 61;
  localparam int GW       = $clog2(N_GROUPS);
  localparam int VW       = N * OUT_W;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [N*ACC_W-1:0]    in_acc;
  logic [N*BIAS_W-1:0]   bias;
  logic                  out_valid;
  logic                  out_ready;
  logic [VW-1:0]         out_act;
  logic [N-1:0]          out_sat;
  logic [GW-1:0]         out_group;
  logic                  out_last;

  always #5 clk = ~clk;

  bias_act_stage #(
    .N_adder_tree (N),
    .ACC_W        (ACC_W),
    .OUT_W        (OUT_W),
    .SHIFT        (SHIFT),
    .N_GROUPS     (N_GROUPS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_act   (out_act),
    .out_sat   (out_sat),
    .out_group (out_group),
    .out_last  (out_last)
  );

  typedef struct {
    logic [VW-1:0] act;
    logic [N-1:0]  sat;
    int            cyc;
  } beat_t;

  beat_t  q[$];
  longint acc_v[N];
  longint bias_v[N];
  int     cyc = 0;
  int     grp = 0;
  int     vectors = 0;
  int     miscompares = 0;
  int     out_count = 0;
  bit     ready_always;

  task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected result from arithmetic: floor division by 2^SHIFT, then clamp, then optional ReLU.
  function automatic beat_t model();
    beat_t  b;
    longint hi  = longint'(2 ** (OUT_W - 1)) - 1;
    longint lo  = -hi - 1;
    longint div = longint'(2 ** SHIFT);
    longint s, sh, r;
    b.act = '0;
    b.sat = '0;
    b.cyc = 0;
    for (int i = 0; i < N; i++) begin
      s  = acc_v[i] + bias_v[i];
      sh = (s >= 0) ? s / div : -((-s + div - 1) / div);
      r  = sh;
      if (sh > hi) begin
        r = hi;
        b.sat[i] = 1'b1;
      end else if (sh < lo) begin
        r = lo;
        b.sat[i] = 1'b1;
      end
`ifdef BIAS_ACT_RELU_EN
      if (r < 0) r = 0;
`endif
      b.act[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
    end
    return b;
  endfunction

  task automatic randomLane(input int i);
    logic signed [ACC_W-1:0]  ta;
    logic signed [BIAS_W-1:0] tb;
    ta = ACC_W'($urandom);
    tb = BIAS_W'($urandom);
    case ($urandom_range(0, 4))
      0:       acc_v[i] = longint'(2 ** (ACC_W - 1)) - 1;
      1:       acc_v[i] = -longint'(2 ** (ACC_W - 1));
      2:       acc_v[i] = longint'($urandom_range(0, 4000)) - 2000;
      default: acc_v[i] = longint'(ta);
    endcase
    case ($urandom_range(0, 3))
      0:       bias_v[i] = longint'(2 ** (BIAS_W - 1)) - 1;
      1:       bias_v[i] = -longint'(2 ** (BIAS_W - 1));
      default: bias_v[i] = longint'(tb);
    endcase
  endtask

  task automatic packInputs();
    for (int i = 0; i < N; i++) begin
      in_acc[i*ACC_W +: ACC_W]   = acc_v[i][ACC_W-1:0];
      bias[i*BIAS_W +: BIAS_W]   = bias_v[i][BIAS_W-1:0];
    end
  endtask

  // One cycle: drive after the falling edge, sample and update the model 2 ns before the rising edge.
  task automatic applyStimulus(input bit v, input bit r, input bit keep, output bit accepted);
    bit exp_valid;
    beat_t b;
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    if (!keep) begin
      for (int i = 0; i < N; i++) randomLane(i);
    end
    packInputs();
    #3;
    exp_valid = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
    checkOutput("out_valid", VW'(out_valid), VW'(exp_valid));
    checkOutput("in_ready", VW'(in_ready), VW'((q.size() < 2) || out_ready));
    if (!in_ready) ready_always = 1'b0;
    if (exp_valid) begin
      checkOutput("out_act", out_act, q[0].act);
      checkOutput("out_sat", VW'(out_sat), VW'(q[0].sat));
      checkOutput("out_group", VW'(out_group), VW'(grp));
      checkOutput("out_last", VW'(out_last), VW'(grp == N_GROUPS - 1));
    end
    if (out_valid && out_ready && q.size() > 0) begin
      void'(q.pop_front());
      grp = (grp == N_GROUPS - 1) ? 0 : grp + 1;
      out_count++;
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      b     = model();
      b.cyc = cyc;
      q.push_back(b);
    end
    cyc++;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_out_valid"}, VW'(out_valid), '0);
    checkOutput({tag, "_out_act"}, out_act, '0);
    checkOutput({tag, "_out_sat"}, VW'(out_sat), '0);
    checkOutput({tag, "_out_group"}, VW'(out_group), '0);
    checkOutput({tag, "_out_last"}, VW'(out_last), VW'(N_GROUPS == 1));
    checkOutput({tag, "_in_ready"}, VW'(in_ready), VW'(1));
  endtask

  initial begin
    bit acc_b;
    int sent;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_acc    = '0;
    bias      = '0;
    #2;
    checkResetState("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < N; i++) randomLane(i);
    acc_v[0] = 80000;     bias_v[0] = -4912;
    acc_v[1] = -160;      bias_v[1] = 0;
    acc_v[2] = 8388607;   bias_v[2] = 131071;
    acc_v[3] = -8388608;  bias_v[3] = -131072;
    applyStimulus(1'b1, 1'b1, 1'b1, acc_b);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 1'b0, acc_b);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b0, acc_b);

    sent = 0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(sent < 5, !(k >= 3 && k <= 6), 1'b0, acc_b);
      if (acc_b) sent++;
    end
    checkOutput("bp_beats_sent", VW'(sent), VW'(5));
    checkOutput("bp_drained", VW'(q.size()), '0);

    applyStimulus(1'b1, 1'b0, 1'b0, acc_b);
    applyStimulus(1'b1, 1'b0, 1'b0, acc_b);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkResetState("midrst");
    q.delete();
    grp = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    sent = 0;
    for (int k = 0; k < 2 * N_GROUPS + 10; k++) begin
      applyStimulus(sent < 2 * N_GROUPS + 1, 1'b1, 1'b0, acc_b);
      if (acc_b) sent++;
    end
    checkOutput("wrap_beats", VW'(sent), VW'(2 * N_GROUPS + 1));
    checkOutput("wrap_group_end", VW'(out_group), VW'(1));

    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0, acc_b);
    end
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b1, 1'b0, acc_b);
    checkOutput("random_drained", VW'(q.size()), '0);

    ready_always = 1'b1;
    out_count    = 0;
    for (int k = 0; k < 100; k++) applyStimulus(1'b1, 1'b1, 1'b0, acc_b);
    checkOutput("fullrate_outputs", VW'(out_count), VW'(98));
    checkOutput("fullrate_in_ready", VW'(ready_always), VW'(1));
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b0, acc_b);
    checkOutput("final_drained", VW'(q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
